rggen_register_host_arbiter: RTL and testbench

- Shares one register-bus host port between HOSTS independent requesters (e.g. CPU bridge and debug/JTAG bridge) in front of the register block.
- Round-robin arbitration with a registered request stage and a registered response stage.
- One access is outstanding at a time.
- An optional timeout counter completes a hung access with an error status.

---
 rtl/rggen_rtl_pkg.sv | 26 ++
 rtl/rggen_round_robin_arbiter.sv | 59 +++++
 rtl/rggen_register_host_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rggen_register_host_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// rtl/rggen_rtl_pkg.sv - shared register-bus types and helpers
// Contents:
//   rggen_status        : register-bus response status encoding
//   rggen_arbiter_state : host arbiter state encoding
//   rggen_clog2_min1    : index/counter width helper that never returns 0
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACCESS   = 2'b01,
    RESPONSE = 2'b10
  } rggen_arbiter_state;

  // Width needed to hold values 0..value-1, never less than one bit.
  function automatic int rggen_clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// rtl/rggen_round_robin_arbiter.sv - round-robin request arbiter with registered priority pointer
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_request      : request vector, one bit per requester
//   i_advance      : take the current winner; pointer moves past it
//   o_grant        : one-hot winner (first request at or after the pointer, wrapping)
//   o_pointer      : current highest-priority requester index
module rggen_round_robin_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS         = 2,
  parameter int POINTER_WIDTH = rggen_clog2_min1(HOSTS)
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [HOSTS-1:0]         i_request,
  input  logic                     i_advance,
  output logic [HOSTS-1:0]         o_grant,
  output logic [POINTER_WIDTH-1:0] o_pointer
);

  logic [POINTER_WIDTH-1:0] winner;
  logic                     found;
  int                       distance;
  int                       best;

  // The winner is the requester with the smallest forward distance from the
  // pointer, which is the same as scanning upward from the pointer and wrapping.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    best     = HOSTS;
    distance = 0;
    for (int h = 0; h < HOSTS; h++) begin
      distance = h - int'(o_pointer);
      if (distance < 0) begin
        distance = distance + HOSTS;
      end
      if (i_request[h] && (distance < best)) begin
        best   = distance;
        winner = POINTER_WIDTH'(h);
        found  = 1'b1;
      end
    end
    o_grant = '0;
    if (found) begin
      o_grant[winner] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_pointer <= '0;
    end else if (i_advance && found) begin
      o_pointer <= (winner == POINTER_WIDTH'(HOSTS - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/rggen_register_host_arbiter.sv
// rtl/rggen_register_host_arbiter.sv - shares one register-bus host port between several requesters
// Ports:
//   i_clk, i_rst_n                       : clock, synchronous active-low reset
//   i_valid, i_address, i_write,
//   i_write_data, i_strobe               : packed per-requester request, slice h is requester h
//   o_ready, o_status, o_read_data       : packed per-requester response, one-cycle pulse
//   o_bus_valid .. o_bus_strobe          : registered downstream request
//   i_bus_ready, i_bus_status,
//   i_bus_read_data                      : downstream response
module rggen_register_host_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS          = 2,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [HOSTS-1:0]                i_valid,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0]  i_address,
  input  logic [HOSTS-1:0]                i_write,
  input  logic [HOSTS*BUS_WIDTH-1:0]      i_write_data,
  input  logic [HOSTS*BUS_WIDTH/8-1:0]    i_strobe,
  output logic [HOSTS-1:0]                o_ready,
  output logic [HOSTS*2-1:0]              o_status,
  output logic [HOSTS*BUS_WIDTH-1:0]      o_read_data,
  output logic                            o_bus_valid,
  output logic [ADDRESS_WIDTH-1:0]        o_bus_address,
  output logic                            o_bus_write,
  output logic [BUS_WIDTH-1:0]            o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]          o_bus_strobe,
  input  logic                            i_bus_ready,
  input  logic [1:0]                      i_bus_status,
  input  logic [BUS_WIDTH-1:0]            i_bus_read_data
);

  localparam int STROBE_WIDTH  = BUS_WIDTH / 8;
  localparam int INDEX_WIDTH   = rggen_clog2_min1(HOSTS);
  localparam int COUNTER_WIDTH = rggen_clog2_min1(TIMEOUT_CYCLES + 1);
  localparam int TIMEOUT_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST = COUNTER_WIDTH'(TIMEOUT_LIMIT);

  rggen_arbiter_state               state;
  logic [HOSTS-1:0]                 grant;
  logic [INDEX_WIDTH-1:0]           grant_index;
  logic [INDEX_WIDTH-1:0]           winner_index;
  logic [ADDRESS_WIDTH-1:0]         winner_address;
  logic                             winner_write;
  logic [BUS_WIDTH-1:0]             winner_write_data;
  logic [STROBE_WIDTH-1:0]          winner_strobe;
  logic [COUNTER_WIDTH-1:0]         timeout_count;
  logic                             request_start;
  logic                             timeout_hit;
  logic                             access_done;
  logic [1:0]                       response_status;
  logic [BUS_WIDTH-1:0]             response_data;
  logic [HOSTS-1:0]                 response_ready;
  logic [HOSTS*2-1:0]               response_status_vec;
  logic [HOSTS*BUS_WIDTH-1:0]       response_data_vec;

  // Arbitration only happens from IDLE, so the pointer moves once per access.
  assign request_start = (state == IDLE) && (|i_valid);

  rggen_round_robin_arbiter #(
    .HOSTS (HOSTS)
  ) u_arbiter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_request (i_valid),
    .i_advance (request_start),
    .o_grant   (grant),
    .o_pointer ()
  );

  // Multiplex the winning requester's payload using the one-hot grant.
  always_comb begin
    winner_index      = '0;
    winner_address    = '0;
    winner_write      = 1'b0;
    winner_write_data = '0;
    winner_strobe     = '0;
    for (int h = 0; h < HOSTS; h++) begin
      if (grant[h]) begin
        winner_index      = INDEX_WIDTH'(h);
        winner_address    = i_address[h*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        winner_write      = i_write[h];
        winner_write_data = i_write_data[h*BUS_WIDTH +: BUS_WIDTH];
        winner_strobe     = i_strobe[h*STROBE_WIDTH +: STROBE_WIDTH];
      end
    end
  end

  // A real bus response in the last allowed cycle beats the timeout.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (timeout_count == TIMEOUT_LAST) && !i_bus_ready;
  assign access_done = (state == ACCESS) && (i_bus_ready || timeout_hit);

  always_comb begin
    response_status     = i_bus_ready ? i_bus_status : RGGEN_SLAVE_ERROR;
    response_data       = i_bus_ready ? i_bus_read_data : '0;
    response_ready      = '0;
    response_status_vec = '0;
    response_data_vec   = '0;
    for (int h = 0; h < HOSTS; h++) begin
      if (grant_index == INDEX_WIDTH'(h)) begin
        response_ready[h]                        = 1'b1;
        response_status_vec[2*h +: 2]            = response_status;
        response_data_vec[h*BUS_WIDTH +: BUS_WIDTH] = response_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      grant_index      <= '0;
      timeout_count    <= '0;
      o_ready          <= '0;
      o_status         <= '0;
      o_read_data      <= '0;
      o_bus_valid      <= 1'b0;
      o_bus_address    <= '0;
      o_bus_write      <= 1'b0;
      o_bus_write_data <= '0;
      o_bus_strobe     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request_start) begin
            state            <= ACCESS;
            grant_index      <= winner_index;
            o_bus_valid      <= 1'b1;
            o_bus_address    <= winner_address;
            o_bus_write      <= winner_write;
            o_bus_write_data <= winner_write_data;
            o_bus_strobe     <= winner_strobe;
          end
        end
        ACCESS: begin
          if (access_done) begin
            state         <= RESPONSE;
            timeout_count <= '0;
            o_bus_valid   <= 1'b0;
            o_ready       <= response_ready;
            o_status      <= response_status_vec;
            o_read_data   <= response_data_vec;
          end else if (TIMEOUT_CYCLES > 0) begin
            timeout_count <= timeout_count + 1'b1;
          end
        end
        RESPONSE: begin
          state       <= IDLE;
          o_ready     <= '0;
          o_status    <= '0;
          o_read_data <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_register_host_arbiter.sv
// tb/tb_rggen_register_host_arbiter.sv - self-checking bench for rggen_register_host_arbiter
module tb_rggen_register_host_arbiter;

  localparam int H  = 3;
  localparam int AW = 16;
  localparam int BW = 32;
  localparam int SW = BW / 8;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [H-1:0]      valid = '0;
  logic [H*AW-1:0]   address = '0;
  logic [H-1:0]      write = '0;
  logic [H*BW-1:0]   write_data = '0;
  logic [H*SW-1:0]   strobe = '0;
  logic [H-1:0]      ready;
  logic [H*2-1:0]    status;
  logic [H*BW-1:0]   read_data;
  logic              bus_valid;
  logic [AW-1:0]     bus_address;
  logic              bus_write;
  logic [BW-1:0]     bus_write_data;
  logic [SW-1:0]     bus_strobe;
  logic              bus_ready = 1'b0;
  logic [1:0]        bus_status = '0;
  logic [BW-1:0]     bus_read_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rggen_register_host_arbiter #(
    .HOSTS          (H),
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_valid          (valid),
    .i_address        (address),
    .i_write          (write),
    .i_write_data     (write_data),
    .i_strobe         (strobe),
    .o_ready          (ready),
    .o_status         (status),
    .o_read_data      (read_data),
    .o_bus_valid      (bus_valid),
    .o_bus_address    (bus_address),
    .o_bus_write      (bus_write),
    .o_bus_write_data (bus_write_data),
    .o_bus_strobe     (bus_strobe),
    .i_bus_ready      (bus_ready),
    .i_bus_status     (bus_status),
    .i_bus_read_data  (bus_read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    valid     = '0;
    bus_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int h, input logic wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] d, input logic [SW-1:0] s);
    address[h*AW +: AW]    = a;
    write[h]               = wr;
    write_data[h*BW +: BW] = d;
    strobe[h*SW +: SW]     = s;
  endtask

  task automatic wait_ready(input int limit, output logic [H-1:0] r, output int lat);
    bit done;
    r    = '0;
    lat  = -1;
    done = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (!done) begin
        step();
        if (ready != '0) begin
          r    = ready;
          lat  = c;
          done = 1'b1;
        end
      end
    end
  endtask

  typedef struct {
    int            host;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    logic [SW-1:0] strb;
    int            ready_delay;   // bus_ready in access cycle ready_delay+1; large = never
    logic [1:0]    bstatus;
    logic [BW-1:0] brdata;
    int            exp_lat;       // cycles from request to o_ready
    logic [1:0]    exp_status;
    logic [BW-1:0] exp_rdata;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  // Scoreboard for the randomized phase.
  int            m_ptr;
  bit            m_active;
  bit            m_resp_due;
  int            m_grant;
  int            m_waited;
  logic          e_bv;
  logic [52:0]   e_payload;
  logic [H-1:0]  e_rdy;
  logic [H*2-1:0] e_st;
  logic [H*BW-1:0] e_rd;
  bit            pend [H];

  task automatic model_respond(input logic [1:0] st, input logic [BW-1:0] rd);
    m_active   = 1'b0;
    m_resp_due = 1'b1;
    e_bv       = 1'b0;
    e_rdy      = H'(1) << m_grant;
    e_st       = (H*2)'(st) << (2 * m_grant);
    e_rd       = (H*BW)'(rd) << (BW * m_grant);
  endtask

  logic [H-1:0]    r_vec;
  logic [H*2-1:0]  st_seen;
  logic [H*BW-1:0] rd_seen;
  int              lat;
  int              first_bv;
  bit              payload_bad;
  bit              bad;
  int              ev_host [6];
  int              ev_cyc [6];
  int              n_ev;
  bit              reassert [H];
  vec_t            v;
  logic [H*2-1:0]  st_mask;
  logic [H*BW-1:0] rd_mask;

  initial begin
    vecs[0] = '{0, 1'b0, 16'h0010, 32'h0,        4'hF, 1,  2'b00, 32'hDEADBEEF, 3, 2'b00, 32'hDEADBEEF};
    vecs[1] = '{1, 1'b1, 16'h0020, 32'h12345678, 4'h5, 2,  2'b00, 32'hA5A5A5A5, 4, 2'b00, 32'hA5A5A5A5};
    vecs[2] = '{2, 1'b0, 16'h1234, 32'h0,        4'hF, 0,  2'b01, 32'h01020304, 2, 2'b01, 32'h01020304};
    vecs[3] = '{0, 1'b0, 16'h00FC, 32'h0,        4'hF, 99, 2'b00, 32'hFFFFFFFF, 5, 2'b10, 32'h0};
    vecs[4] = '{1, 1'b0, 16'hFFFF, 32'h0,        4'hF, 3,  2'b11, 32'hBEEF0001, 5, 2'b11, 32'hBEEF0001};
    vecs[5] = '{2, 1'b1, 16'h0000, 32'h0BADF00D, 4'h3, 99, 2'b01, 32'h11111111, 5, 2'b10, 32'h0};
    vecs[6] = '{0, 1'b1, 16'h8000, 32'hCAFEF00D, 4'h8, 0,  2'b10, 32'h00000055, 2, 2'b10, 32'h00000055};

    // Reset state.
    do_reset();
    check("reset_bus_valid", bus_valid, 0);
    check("reset_ready", ready, 0);
    check("reset_status", status, 0);
    check("reset_read_data", read_data, 0);
    check("reset_bus_payload", {bus_address, bus_write, bus_write_data, bus_strobe}, 0);

    // Table-driven single transactions.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      set_req(v.host, v.wr, v.addr, v.wdata, v.strb);
      valid       = H'(1) << v.host;
      first_bv    = -1;
      lat         = -1;
      r_vec       = '0;
      st_seen     = '0;
      rd_seen     = '0;
      payload_bad = 1'b0;
      for (int c = 1; c <= 12; c++) begin
        if (lat < 0) begin
          step();
          if (bus_valid && first_bv < 0) first_bv = c;
          if (bus_valid && ({bus_address, bus_write, bus_write_data, bus_strobe} !==
                            {v.addr, v.wr, v.wdata, v.strb})) payload_bad = 1'b1;
          if (ready != '0) begin
            lat     = c;
            r_vec   = ready;
            st_seen = status;
            rd_seen = read_data;
            valid   = '0;
          end
          bus_ready     = (c == 1 + v.ready_delay);
          bus_status    = v.bstatus;
          bus_read_data = v.brdata;
        end
      end
      bus_ready = 1'b0;
      valid     = '0;
      step();
      st_mask = ~((H*2)'(3) << (2 * v.host));
      rd_mask = ~((H*BW)'(32'hFFFFFFFF) << (BW * v.host));
      check($sformatf("vec%0d_first_bus_valid", i), 128'(first_bv), 1);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(v.exp_lat));
      check($sformatf("vec%0d_ready_vector", i), r_vec, H'(1) << v.host);
      check($sformatf("vec%0d_status", i), st_seen[2*v.host +: 2], v.exp_status);
      check($sformatf("vec%0d_read_data", i), rd_seen[BW*v.host +: BW], v.exp_rdata);
      check($sformatf("vec%0d_other_status", i), st_seen & st_mask, 0);
      check($sformatf("vec%0d_other_data", i), rd_seen & rd_mask, 0);
      check($sformatf("vec%0d_payload_stable", i), 128'(payload_bad), 0);
    end

    // Reset in the middle of an access.
    rst_n     = 1'b0;
    bus_ready = 1'b0;
    set_req(1, 1'b0, 16'h0040, 32'h0, 4'hF);
    valid = 3'b010;
    step();
    rst_n = 1'b1;
    step();
    check("rstmid_bus_valid_up", bus_valid, 1);
    step();
    step();
    rst_n = 1'b0;
    valid = '0;
    step();
    check("rstmid_bus_valid_cleared", bus_valid, 0);
    check("rstmid_no_ready", ready, 0);
    rst_n = 1'b1;
    bad   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus_valid || ready != '0) bad = 1'b1;
    end
    check("rstmid_quiet_after", 128'(bad), 0);
    set_req(1, 1'b0, 16'h0044, 32'h0, 4'hF);
    set_req(2, 1'b0, 16'h0048, 32'h0, 4'hF);
    valid = 3'b110;
    wait_ready(12, r_vec, lat);
    check("rstmid_next_grant", r_vec, 3'b010);
    check("rstmid_fresh_timeout", 128'(lat), 5);
    check("rstmid_timeout_status", status[3:2], 2'b10);
    valid = '0;
    step();

    // Contention: all requesters continuously valid, bus always ready.
    do_reset();
    for (int h = 0; h < H; h++) begin
      set_req(h, 1'b0, AW'(h * 256 + 4), 32'h0, 4'hF);
      reassert[h] = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      ev_host[i] = -1;
      ev_cyc[i]  = -100;
    end
    valid     = 3'b111;
    bus_ready = 1'b1;
    n_ev      = 0;
    for (int c = 0; c < 40; c++) begin
      if (n_ev < 6) begin
        step();
        for (int h = 0; h < H; h++) begin
          if (reassert[h]) begin
            valid[h]    = 1'b1;
            reassert[h] = 1'b0;
          end
        end
        for (int h = 0; h < H; h++) begin
          if (ready[h] && n_ev < 6) begin
            ev_host[n_ev] = h;
            ev_cyc[n_ev]  = cyc;
            n_ev++;
            valid[h]    = 1'b0;
            reassert[h] = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("contention_order%0d", i), 128'(ev_host[i]), 128'(i % H));
    end
    for (int i = 1; i < 6; i++) begin
      check($sformatf("contention_spacing%0d", i), 128'(ev_cyc[i] - ev_cyc[i-1]), 3);
    end
    valid     = '0;
    bus_ready = 1'b0;
    step();
    step();

    // Pointer wrap: a grant to the last requester hands priority back to 0.
    do_reset();
    bus_ready = 1'b1;
    set_req(0, 1'b0, 16'h0100, 32'h0, 4'hF);
    set_req(2, 1'b0, 16'h0300, 32'h0, 4'hF);
    valid = 3'b100;
    wait_ready(10, r_vec, lat);
    check("wrap_first_grant", r_vec, 3'b100);
    valid = '0;
    step();
    valid = 3'b101;
    wait_ready(10, r_vec, lat);
    check("wrap_second_grant", r_vec, 3'b001);
    valid[0] = 1'b0;
    wait_ready(10, r_vec, lat);
    check("wrap_third_grant", r_vec, 3'b100);
    valid     = '0;
    bus_ready = 1'b0;
    step();

    // Randomized traffic against the scoreboard.
    do_reset();
    m_ptr      = 0;
    m_active   = 1'b0;
    m_resp_due = 1'b0;
    m_grant    = 0;
    m_waited   = 0;
    e_bv       = 1'b0;
    e_payload  = '0;
    e_rdy      = '0;
    e_st       = '0;
    e_rd       = '0;
    for (int h = 0; h < H; h++) pend[h] = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      check("rnd_bus_valid", bus_valid, e_bv);
      if (e_bv) check("rnd_bus_payload", {bus_address, bus_write, bus_write_data, bus_strobe}, e_payload);
      check("rnd_ready", ready, e_rdy);
      check("rnd_status", status, e_st);
      check("rnd_read_data", read_data, e_rd);

      // Requesters: drop on completion, otherwise sometimes start a new request.
      for (int h = 0; h < H; h++) begin
        if (ready[h]) begin
          pend[h]  = 1'b0;
          valid[h] = 1'b0;
        end else if (!pend[h] && $urandom_range(0, 2) == 0) begin
          pend[h] = 1'b1;
          set_req(h, 1'(($urandom_range(0, 1))), AW'($urandom), $urandom, SW'($urandom));
          valid[h] = 1'b1;
        end
      end
      bus_ready     = ($urandom_range(0, 3) == 0);
      bus_status    = 2'($urandom);
      bus_read_data = $urandom;

      // Predict the next cycle.
      if (m_resp_due) begin
        m_resp_due = 1'b0;
        e_rdy      = '0;
        e_st       = '0;
        e_rd       = '0;
      end else if (m_active) begin
        if (bus_ready) begin
          model_respond(bus_status, bus_read_data);
        end else begin
          m_waited++;
          if (m_waited == TO) model_respond(2'b10, '0);
        end
      end else begin
        for (int k = H - 1; k >= 0; k--) begin
          if (valid[(m_ptr + k) % H]) m_grant = (m_ptr + k) % H;
        end
        if (valid != '0) begin
          m_active  = 1'b1;
          m_waited  = 0;
          e_bv      = 1'b1;
          e_payload = {address[m_grant*AW +: AW], write[m_grant],
                       write_data[m_grant*BW +: BW], strobe[m_grant*SW +: SW]};
          m_ptr     = (m_grant + 1) % H;
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
